// File: rtl/saida_serial_bcd_n.sv
// saida_serial_bcd_n: latches packed BCD digits on partida and sends them MSB-first as
// 7-bit ASCII UART frames with parity, followed by a terminator character.
module saida_serial_bcd_n #(
  parameter int         N_DIGITOS      = 3,
  parameter int         CICLOS_POR_BIT = 434,
  parameter int         PARIDADE_IMPAR = 1,
  parameter int         STOP_BITS      = 1,
  parameter logic [6:0] TERMINADOR     = 7'h23,
  parameter int         SUPRIME_ZEROS  = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   partida,
  input  logic [4*N_DIGITOS-1:0] dados,
  output logic                   saida_serial,
  output logic                   ocupado,
  output logic                   pronto,
  output logic [2:0]             db_estado
);
  localparam int DW = 4 * N_DIGITOS;
  localparam int FW = 9 + STOP_BITS;
  localparam int CW = $clog2(CICLOS_POR_BIT);
  localparam int BW = $clog2(FW);
  localparam int NW = $clog2(N_DIGITOS + 1);
  localparam logic [2:0] INICIAL = 3'd0, CARREGA = 3'd1, TRANSMITE = 3'd2, FINAL = 3'd4;

  function automatic logic [6:0] ascii(input logic [3:0] d);
    return (d <= 4'd9) ? {3'b011, d} : 7'h3F;
  endfunction

  // frame is stored LSB first: start, 7 data bits, parity, stop bits
  function automatic logic [FW-1:0] quadro(input logic [6:0] c);
    return {{STOP_BITS{1'b1}}, ^c ^ (PARIDADE_IMPAR != 0), c, 1'b0};
  endfunction

  logic [2:0]    estado_q, estado_d;
  logic [DW-1:0] sr_q, sr_d, sr_ini, sr_prox;
  logic [NW-1:0] rem_q, rem_d, lz;
  logic [FW-1:0] quadro_q, quadro_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic          linha_q, linha_d, ocupado_q, ocupado_d, pronto_q, pronto_d;
  logic          zeros, fim_bit, fim_quadro;

  // leading zeros among all but the least significant digit; non-BCD never counts as zero
  always_comb begin
    lz = '0;
    zeros = SUPRIME_ZEROS != 0;
    for (int i = N_DIGITOS - 1; i > 0; i--) begin
      zeros = zeros && (sr_q[4*i +: 4] == 4'd0);
      lz = lz + NW'(zeros);
    end
  end

  assign sr_ini     = sr_q << (4 * lz);
  assign sr_prox    = sr_q << 4;
  assign fim_bit    = cyc_q == CW'(CICLOS_POR_BIT - 1);
  assign fim_quadro = fim_bit && (bit_q == BW'(FW - 1));

  // rem_q counts frames still to send after the current one, terminator included
  always_comb begin
    estado_d  = estado_q;
    sr_d      = sr_q;
    rem_d     = rem_q;
    quadro_d  = quadro_q;
    bit_d     = bit_q;
    cyc_d     = cyc_q;
    ocupado_d = ocupado_q;
    pronto_d  = 1'b0;
    linha_d   = (estado_q == TRANSMITE) ? quadro_q[bit_q] : 1'b1;
    case (estado_q)
      INICIAL: if (partida) begin
        estado_d  = CARREGA;
        sr_d      = dados;
        ocupado_d = 1'b1;
      end
      CARREGA: begin
        estado_d = TRANSMITE;
        sr_d     = sr_ini;
        rem_d    = NW'(N_DIGITOS) - lz;
        quadro_d = quadro(ascii(sr_ini[DW-1 -: 4]));
        bit_d    = '0;
        cyc_d    = '0;
      end
      TRANSMITE: begin
        cyc_d = fim_bit ? '0 : cyc_q + 1'b1;
        bit_d = fim_quadro ? '0 : bit_q + BW'(fim_bit);
        if (fim_quadro) begin
          estado_d = (rem_q == '0) ? FINAL : TRANSMITE;
          rem_d    = rem_q - 1'b1;
          sr_d     = sr_prox;
          quadro_d = (rem_q == NW'(1)) ? quadro(TERMINADOR) : quadro(ascii(sr_prox[DW-1 -: 4]));
        end
      end
      FINAL: begin
        estado_d  = INICIAL;
        pronto_d  = 1'b1;
        ocupado_d = 1'b0;
      end
      default: estado_d = INICIAL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q  <= INICIAL;
      sr_q      <= '0;
      rem_q     <= '0;
      quadro_q  <= '0;
      bit_q     <= '0;
      cyc_q     <= '0;
      linha_q   <= 1'b1;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      sr_q      <= sr_d;
      rem_q     <= rem_d;
      quadro_q  <= quadro_d;
      bit_q     <= bit_d;
      cyc_q     <= cyc_d;
      linha_q   <= linha_d;
      ocupado_q <= ocupado_d;
      pronto_q  <= pronto_d;
    end
  end

  assign saida_serial = linha_q;
  assign ocupado      = ocupado_q;
  assign pronto       = pronto_q;
  assign db_estado    = estado_q;
endmodule

// File: tb/tb_saida_serial_bcd_n.sv
// tb_saida_serial_bcd_n: three configurations driven with fixed and random BCD messages,
// line/ocupado/pronto checked every cycle against an expected bit stream.
module tb_saida_serial_bcd_n;
  localparam int CPB = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       partida [3];
  logic [11:0] dados  [3];
  logic       linha   [3];
  logic       ocup    [3];
  logic       pron    [3];
  logic [2:0] est     [3];
  int         n_cmp = 0;
  int         n_err = 0;
  logic       esp [$];

  always #5 clock = ~clock;

  saida_serial_bcd_n #(.N_DIGITOS(3), .CICLOS_POR_BIT(CPB)) u0 (
    .clock(clock), .reset(reset), .partida(partida[0]), .dados(dados[0]),
    .saida_serial(linha[0]), .ocupado(ocup[0]), .pronto(pron[0]), .db_estado(est[0]));
  saida_serial_bcd_n #(.N_DIGITOS(3), .CICLOS_POR_BIT(CPB), .SUPRIME_ZEROS(1)) u1 (
    .clock(clock), .reset(reset), .partida(partida[1]), .dados(dados[1]),
    .saida_serial(linha[1]), .ocupado(ocup[1]), .pronto(pron[1]), .db_estado(est[1]));
  saida_serial_bcd_n #(.N_DIGITOS(3), .CICLOS_POR_BIT(CPB), .PARIDADE_IMPAR(0), .STOP_BITS(2)) u2 (
    .clock(clock), .reset(reset), .partida(partida[2]), .dados(dados[2]),
    .saida_serial(linha[2]), .ocupado(ocup[2]), .pronto(pron[2]), .db_estado(est[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // expected line bits for a whole message on instance u
  task automatic modelo(input int u, input logic [11:0] d);
    logic [6:0] cs [$];
    bit lead = (u == 1);
    esp.delete();
    for (int i = 2; i >= 0; i--) begin
      int dg = int'(d >> (4 * i)) & 15;
      if (lead && dg == 0 && i > 0) continue;
      lead = 0;
      cs.push_back(dg <= 9 ? 7'(48 + dg) : 7'h3F);
    end
    cs.push_back(7'h23);
    foreach (cs[k]) begin
      int ones = $countones(cs[k]);
      esp.push_back(1'b0);
      for (int b = 0; b < 7; b++) esp.push_back(cs[k][b]);
      esp.push_back((u == 2) ? (ones % 2 == 1) : (ones % 2 == 0));
      repeat ((u == 2) ? 2 : 1) esp.push_back(1'b1);
    end
  endtask

  task automatic msg(input int u, input logic [11:0] d, input bit pre_high, input bit keep_high, input bit muda);
    int total;
    modelo(u, d);
    total = 2 + esp.size() * CPB;
    dados[u] = d;
    if (!pre_high) begin
      @(negedge clock);
      partida[u] = 1'b1;
    end
    @(posedge clock);
    #1;
    if (!keep_high) partida[u] = 1'b0;
    if (muda) dados[u] = ~d;
    for (int t = 0; t <= total; t++) begin
      if (t > 0) begin
        @(posedge clock);
        #1;
      end
      if (keep_high && t == 50) partida[u] = 1'b0;
      if (keep_high && t == 52) partida[u] = 1'b1;
      chk($sformatf("u%0d %03h linha t=%0d", u, d, t), linha[u], (t >= 2 && t < total) ? esp[(t-2)/CPB] : 1'b1);
      chk($sformatf("u%0d %03h ocupado t=%0d", u, d, t), ocup[u], t < total);
      chk($sformatf("u%0d %03h pronto t=%0d", u, d, t), pron[u], t == total);
    end
  endtask

  function automatic logic [11:0] rnd_dados();
    logic [11:0] r = '0;
    for (int i = 0; i < 3; i++)
      r[4*i +: 4] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    return r;
  endfunction

  initial begin
    for (int i = 0; i < 3; i++) begin
      partida[i] = 1'b0;
      dados[i] = '0;
    end
    repeat (3) @(posedge clock);
    #1;
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("reset linha u%0d", u), linha[u], 1'b1);
      chk($sformatf("reset ocupado u%0d", u), ocup[u], 1'b0);
      chk($sformatf("reset pronto u%0d", u), pron[u], 1'b0);
    end
    @(negedge clock);
    reset = 1'b1;
    msg(0, 12'h705, 0, 0, 0);
    msg(1, 12'h005, 0, 0, 0);
    msg(1, 12'h000, 0, 0, 0);
    msg(1, 12'h0A0, 0, 0, 0);
    msg(0, 12'h1A9, 0, 0, 0);
    msg(2, 12'h1A9, 0, 0, 0);
    msg(0, 12'h384, 0, 1, 0);
    msg(0, 12'h926, 1, 0, 0);
    msg(1, 12'h042, 0, 0, 1);
    msg(0, 12'h618, 0, 0, 1);
    for (int r = 0; r < 6; r++)
      for (int u = 0; u < 3; u++) msg(u, rnd_dados(), 0, 0, 1'($urandom_range(0, 1)));
    // reset during data bit 3 of the second frame ('0' = 0x30, bit 3 low)
    @(negedge clock);
    dados[0] = 12'h705;
    partida[0] = 1'b1;
    @(posedge clock);
    #1;
    partida[0] = 1'b0;
    repeat (59) @(posedge clock);
    #1;
    chk("pre-reset linha", linha[0], 1'b0);
    chk("pre-reset ocupado", ocup[0], 1'b1);
    reset = 1'b0;
    #1;
    chk("async reset linha", linha[0], 1'b1);
    chk("async reset ocupado", ocup[0], 1'b0);
    @(negedge clock);
    reset = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(posedge clock);
      #1;
      chk($sformatf("post-reset linha t=%0d", t), linha[0], 1'b1);
      chk($sformatf("post-reset ocupado t=%0d", t), ocup[0], 1'b0);
      chk($sformatf("post-reset pronto t=%0d", t), pron[0], 1'b0);
    end
    msg(0, 12'h705, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
